// File: rtl/bcd_result_converter.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one iteration per clock).
// Optional signed input via `BCD_SIGNED_INPUT_EN; the default build treats `value` as unsigned.
module bcd_result_converter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [7:0]  mag;
    logic        sign;
    logic [11:0] scratch;

    logic [7:0]  in_mag;
    logic        in_sign;
    logic [11:0] adj;
    logic [11:0] next_scratch;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
`ifdef BCD_SIGNED_INPUT_EN
        in_sign = value[7];
        in_mag  = value[7] ? (~value + 8'd1) : value;
`else
        in_sign = 1'b0;
        in_mag  = value;
`endif
        adj          = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
        next_scratch = {adj[10:0], mag[7]};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            mag     <= 8'd0;
            sign    <= 1'b0;
            scratch <= 12'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            bcd1    <= 4'h0;
            bcd2    <= 4'h0;
            bcd3    <= 4'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag     <= in_mag;
                        sign    <= in_sign;
                        scratch <= 12'd0;
                        cnt     <= 3'd0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    mag     <= {mag[6:0], 1'b0};
                    cnt     <= cnt + 3'd1;
                    // The eighth iteration publishes the result straight from the shift path.
                    if (cnt == 3'd7) begin
                        bcd1  <= next_scratch[11:8];
                        bcd2  <= next_scratch[7:4];
                        bcd3  <= next_scratch[3:0];
                        neg   <= sign;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_result_converter.sv
// Directed self-checking bench for bcd_result_converter; expectations follow `BCD_SIGNED_INPUT_EN.
module tb_bcd_result_converter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] value = 8'd0;
    logic       busy, done, neg;
    logic [3:0] bcd1, bcd2, bcd3;

    int errors = 0;
    int checks = 0;
    logic [12:0] prev_out = 13'd0;  // {neg, bcd1, bcd2, bcd3} of the last completed conversion

    bcd_result_converter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .value(value),
        .busy (busy),
        .done (done),
        .neg  (neg),
        .bcd1 (bcd1),
        .bcd2 (bcd2),
        .bcd3 (bcd3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] outs();
        return {neg, bcd1, bcd2, bcd3};
    endfunction

    // Full conversion with handshake and hold checks at every cycle.
    task automatic convert(input logic [7:0] v, input logic [12:0] exp, input string tag);
        value = v;
        start = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", tag, busy, done);
        end
        start = 1'b0;
        value = ~v;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || outs() !== prev_out) begin
                errors++;
                $display("FAIL %s shift%0d: busy=%b done=%b out=%h, required busy=1 done=0 out=%h",
                         tag, i, busy, done, outs(), prev_out);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || outs() !== exp) begin
            errors++;
            $display("FAIL %s done: busy=%b done=%b out=%h, required busy=0 done=1 out=%h",
                     tag, busy, done, outs(), exp);
        end
        prev_out = exp;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || outs() !== exp) begin
            errors++;
            $display("FAIL %s hold: busy=%b done=%b out=%h, required busy=0 done=0 out=%h",
                     tag, busy, done, outs(), exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, outs()} !== 15'd0) begin
            errors++;
            $display("FAIL reset_init: got %h, required 0", {busy, done, outs()});
        end
        rst_n = 1'b1;
        value = 8'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, outs()} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h, required 0", {busy, done, outs()});
        end
        tick();
        rst_n = 1'b1;
        prev_out = 13'd0;
    endtask

    task automatic test_basic();
        convert(8'd37, {1'b0, 4'd0, 4'd3, 4'd7}, "conv37");
        convert(8'd255,
`ifdef BCD_SIGNED_INPUT_EN
                {1'b1, 4'd0, 4'd0, 4'd1},
`else
                {1'b0, 4'd2, 4'd5, 4'd5},
`endif
                "conv255");
    endtask

    task automatic test_sign();
`ifdef BCD_SIGNED_INPUT_EN
        convert(8'hD6, {1'b1, 4'd0, 4'd4, 4'd2}, "convD6");
        convert(8'h80, {1'b1, 4'd1, 4'd2, 4'd8}, "conv80");
`else
        convert(8'hD6, {1'b0, 4'd2, 4'd1, 4'd4}, "convD6");
        convert(8'h80, {1'b0, 4'd1, 4'd2, 4'd8}, "conv80");
`endif
        convert(8'h00, {1'b0, 4'd0, 4'd0, 4'd0}, "conv00");
    endtask

    task automatic test_start_ignored();
        int n_done = 0;
        value = 8'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        value = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 4; i <= 7; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (outs() !== prev_out) begin
            errors++;
            $display("FAIL ign_hold: out=%h, required %h", outs(), prev_out);
        end
        tick();
        checks++;
        if (done !== 1'b1 || outs() !== {1'b0, 4'd0, 4'd9, 4'd9}) begin
            errors++;
            $display("FAIL ign_result: done=%b out=%h, required done=1 out=0099", done, outs());
        end
        prev_out = {1'b0, 4'd0, 4'd9, 4'd9};
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_extra: extra done pulses=%0d busy=%b, required 0 and 0", n_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        value = 8'd127;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp_done = (k % 9 == 8);
            checks++;
            if (done !== exp_done || busy !== !exp_done) begin
                errors++;
                $display("FAIL b2b_hs k=%0d: done=%b busy=%b, required done=%b busy=%b",
                         k, done, busy, exp_done, !exp_done);
            end
            if (k >= 8) begin
                checks++;
                if (outs() !== {1'b0, 4'd1, 4'd2, 4'd7}) begin
                    errors++;
                    $display("FAIL b2b_out k=%0d: out=%h, required 0127", k, outs());
                end
            end
        end
        start = 1'b0;
        prev_out = {1'b0, 4'd1, 4'd2, 4'd7};
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        value = 8'd64;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, outs()} !== 15'd0) begin
            errors++;
            $display("FAIL abort_out: got %h, required 0", {busy, done, outs()});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL abort_done: spurious activity=%0d, required 0", n_done);
        end
        prev_out = 13'd0;
        convert(8'd7, {1'b0, 4'd0, 4'd0, 4'd7}, "conv7");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
